i2c_mem_ctrl: RTL

I2C_MEM_CTRL -- requirements
Module: i2c_mem_ctrl

---
 rtl/i2c_mem_ctrl.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_mem_ctrl.sv
// I2C slave exposing an internal byte memory: device-address match, big-endian
// memory address bytes, sequential writes and reads with an auto-incrementing pointer.
module i2c_mem_ctrl #(
    parameter logic [6:0] DEV_ADDR   = 7'h50,
    parameter int         ADDR_BYTES = 1,
    parameter int         DEPTH      = 256,
    localparam int        AW         = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl_in,
    input  logic          sda_in,
    output logic          sda_oe,
    output logic          busy,
    output logic          wr_pulse,
    output logic [AW-1:0] ptr
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        DEV       = 4'd1,
        DEV_ACK   = 4'd2,
        MADDR     = 4'd3,
        MADDR_ACK = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RD_ACK    = 4'd8,
        WAIT_STOP = 4'd9
    } state_t;

    // Pin synchronisers: _p0/_p1 form the two-flop synchroniser, _p2 is the history flop
    logic scl_p0, scl_p1, scl_p2;
    logic sda_p0, sda_p1, sda_p2;

    logic scl_rise, scl_fall, start_det, stop_det;

    state_t        state, state_nx;
    logic [2:0]    bit_cnt, bit_nx;
    logic [1:0]    addr_cnt, acnt_nx;
    logic          rw_flag, rw_nx;
    logic          oe_nx, wr_nx;
    logic [AW-1:0] ptr_nx;
    logic [7:0]    shreg, sh_nx;
    logic [7:0]    addr_hi, hi_nx;
    logic [7:0]    byte_in, rd_byte;
    logic          mem_we;

    logic [7:0]    mem [DEPTH];

    // Two-flop synchronisers plus history flop; idle bus level is high
    always_ff @(posedge clk) begin
        if (!rst) begin
            scl_p0 <= 1'b1;
            scl_p1 <= 1'b1;
            scl_p2 <= 1'b1;
            sda_p0 <= 1'b1;
            sda_p1 <= 1'b1;
            sda_p2 <= 1'b1;
        end else begin
            scl_p0 <= scl_in;
            scl_p1 <= scl_p0;
            scl_p2 <= scl_p1;
            sda_p0 <= sda_in;
            sda_p1 <= sda_p0;
            sda_p2 <= sda_p1;
        end
    end

    assign scl_rise  =  scl_p1 & ~scl_p2;
    assign scl_fall  = ~scl_p1 &  scl_p2;
    assign start_det = ~sda_p1 &  sda_p2 & scl_p1;
    assign stop_det  =  sda_p1 & ~sda_p2 & scl_p1;

    assign byte_in = {shreg[6:0], sda_p1};
    assign rd_byte = mem[ptr];
    assign busy    = (state != IDLE);

    // Next-state and output decode; START/STOP take priority over SCL edges
    always_comb begin
        state_nx = state;
        bit_nx   = bit_cnt;
        acnt_nx  = addr_cnt;
        rw_nx    = rw_flag;
        oe_nx    = sda_oe;
        wr_nx    = 1'b0;
        ptr_nx   = ptr;
        sh_nx    = shreg;
        hi_nx    = addr_hi;
        mem_we   = 1'b0;

        if (stop_det) begin
            state_nx = IDLE;
            oe_nx    = 1'b0;
            bit_nx   = 3'd0;
        end else if (start_det) begin
            state_nx = DEV;
            oe_nx    = 1'b0;
            bit_nx   = 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    oe_nx = 1'b0;
                end

                DEV: begin
                    if (scl_rise) begin
                        sh_nx  = byte_in;
                        bit_nx = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            bit_nx = 3'd0;
                            if (byte_in[7:1] == DEV_ADDR) begin
                                state_nx = DEV_ACK;
                                rw_nx    = byte_in[0];
                                acnt_nx  = 2'd0;
                            end else begin
                                state_nx = WAIT_STOP;
                            end
                        end
                    end
                end

                MADDR: begin
                    if (scl_rise) begin
                        sh_nx  = byte_in;
                        bit_nx = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            bit_nx   = 3'd0;
                            hi_nx    = byte_in;
                            acnt_nx  = addr_cnt + 2'd1;
                            state_nx = MADDR_ACK;
                            if (addr_cnt == 2'(ADDR_BYTES - 1))
                                ptr_nx = AW'({(ADDR_BYTES == 2) ? addr_hi : 8'h00, byte_in});
                        end
                    end
                end

                WDATA: begin
                    if (scl_rise) begin
                        sh_nx  = byte_in;
                        bit_nx = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            bit_nx   = 3'd0;
                            mem_we   = 1'b1;
                            wr_nx    = 1'b1;
                            ptr_nx   = ptr + 1'b1;
                            state_nx = WDATA_ACK;
                        end
                    end
                end

                // ACK slot: bit_cnt marks whether the master has clocked the ACK bit yet
                DEV_ACK, MADDR_ACK, WDATA_ACK: begin
                    if (scl_rise) begin
                        bit_nx = 3'd1;
                    end else if (scl_fall && bit_cnt == 3'd0) begin
                        oe_nx = 1'b1;
                    end else if (scl_fall) begin
                        oe_nx  = 1'b0;
                        bit_nx = 3'd0;
                        if (state == DEV_ACK && rw_flag) begin
                            state_nx = RDATA;
                            sh_nx    = rd_byte;
                            oe_nx    = ~rd_byte[7];
                        end else if (state == DEV_ACK) begin
                            state_nx = MADDR;
                        end else if (state == MADDR_ACK && addr_cnt != 2'(ADDR_BYTES)) begin
                            state_nx = MADDR;
                        end else begin
                            state_nx = WDATA;
                        end
                    end
                end

                RDATA: begin
                    if (scl_rise) begin
                        bit_nx = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            bit_nx   = 3'd0;
                            state_nx = RD_ACK;
                        end
                    end else if (scl_fall) begin
                        sh_nx = {shreg[6:0], 1'b0};
                        oe_nx = ~shreg[6];
                    end
                end

                // Master ACK slot after a read byte: release, sample, then reload on ACK
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_p1) begin
                            state_nx = WAIT_STOP;
                        end else begin
                            ptr_nx = ptr + 1'b1;
                            bit_nx = 3'd1;
                        end
                    end else if (scl_fall && bit_cnt == 3'd0) begin
                        oe_nx = 1'b0;
                    end else if (scl_fall) begin
                        state_nx = RDATA;
                        bit_nx   = 3'd0;
                        sh_nx    = rd_byte;
                        oe_nx    = ~rd_byte[7];
                    end
                end

                WAIT_STOP: begin
                    oe_nx = 1'b0;
                end

                default: begin
                    state_nx = IDLE;
                    oe_nx    = 1'b0;
                end
            endcase
        end
    end

    // Control registers are reset; shift and address-byte holding registers are not
    always_ff @(posedge clk) begin
        shreg   <= sh_nx;
        addr_hi <= hi_nx;
        if (!rst) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            addr_cnt <= 2'd0;
            rw_flag  <= 1'b0;
            sda_oe   <= 1'b0;
            wr_pulse <= 1'b0;
            ptr      <= '0;
        end else begin
            state    <= state_nx;
            bit_cnt  <= bit_nx;
            addr_cnt <= acnt_nx;
            rw_flag  <= rw_nx;
            sda_oe   <= oe_nx;
            wr_pulse <= wr_nx;
            ptr      <= ptr_nx;
        end
    end

    // Byte memory write port; contents survive reset
    always_ff @(posedge clk) begin
        if (rst && mem_we)
            mem[ptr] <= byte_in;
    end

endmodule
